lemmings_ctrl: RTL
==================

LEMMINGS_CTRL -- requirements
Module: lemmings_ctrl

Interface
REQ-001 SHALL have parameter FALL_LIMIT, default 20: maximum number of consecutive falling cycles that still land safely.
REQ-002 SHALL have parameter CNT_W, default 5: fall-counter width; SHALL satisfy 2^CNT_W-1 >= FALL_LIMIT (elaboration error otherwise).
REQ-003 SHALL have port sys_clk, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port sys_rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port bump_left, input, 1 bit: obstacle on the left.
REQ-006 SHALL have port bump_right, input, 1 bit: obstacle on the right.
REQ-007 SHALL have port ground, input, 1 bit: ground present under the lemming.
REQ-008 SHALL have port dig, input, 1 bit: dig request.
REQ-009 SHALL have ports walk_left and walk_right, output, 1 bit each: walking in that direction.
REQ-010 SHALL have port aaah, output, 1 bit: falling.
REQ-011 SHALL have port digging, output, 1 bit: digging.
REQ-012 SHALL have port splat, output, 1 bit: dead; present only with the splat macro (see REQ-026).
REQ-013 SHALL have port fall_cnt, output, CNT_W bits: current fall-cycle count.

Function
REQ-014 SHALL be a Moore FSM with states WALK_L, WALK_R, FALL_L, FALL_R, DIG_L, DIG_R and SPLAT; all outputs decode from state and counter only.
REQ-015 WALK_x transitions SHALL use this priority: ground=0 -> FALL_x; else dig=1 -> DIG_x; else bump toward the current direction -> WALK of the opposite direction; else stay.
- WALK_L uses bump_left; WALK_R uses bump_right.
- A bump on the opposite side is ignored.
- bump_left=bump_right=1 reverses direction.
REQ-016 DIG_x SHALL go to FALL_x when ground=0 and otherwise stay; bump and dig are ignored.
REQ-017 FALL_x SHALL stay while ground=0; bump and dig are ignored.
- On ground=1 with fall_cnt >= FALL_LIMIT: go to SPLAT.
- On ground=1 otherwise: go to WALK_x in the original direction.
REQ-018 SPLAT SHALL be absorbing until sys_rst; all inputs are ignored.
REQ-019 fall_cnt SHALL be 0 in every state other than FALL_x.
- In FALL_x it increments by 1 per cycle and saturates at 2^CNT_W-1 (no wrap).
- It reads 0 during the first FALL cycle, so a fall of N cycles has fall_cnt=N-1 on the landing cycle.
- Falls of 1..FALL_LIMIT cycles land safely; falls of FALL_LIMIT+1 or more cycles splat.
REQ-020 Output mapping:
- walk_left=WALK_L; walk_right=WALK_R.
- aaah=FALL_L|FALL_R.
- digging=DIG_L|DIG_R.
- splat=SPLAT.
- All outputs are 0 in SPLAT except splat.
- Exactly one of the state outputs is high in any cycle.
REQ-021 Input-to-output latency SHALL be exactly one clock; there are no combinational input-to-output paths.

Reset
REQ-022 sys_rst=1 at a rising edge SHALL force state WALK_L and fall_cnt=0, with priority over all inputs.
REQ-023 Output values after reset SHALL be walk_left=1 with all other outputs 0.
REQ-024 Reset mid-fall, mid-dig or in SPLAT SHALL behave identically to REQ-022 and REQ-023.
REQ-025 No output SHALL depend on asynchronous logic.

Configuration
REQ-026 With macro LEMMINGS_CTRL_SPLAT_EN defined, SPLAT, the splat port and the REQ-017 threshold check SHALL exist.
REQ-027 Without LEMMINGS_CTRL_SPLAT_EN, SPLAT and the splat port SHALL be absent.
- Every landing goes to WALK_x regardless of fall duration.
- fall_cnt still counts and saturates.

Structure
REQ-028 A shared package lemmings_pkg SHALL hold:
- the state enum typedef lem_state_t with 3-bit encoding;
- the default FALL_LIMIT and CNT_W constants.
REQ-029 The fall counter SHALL be one sub-module, lemmings_fall_cnt, with ports clk, rst, en and cnt; it implements saturating increment and clear when en=0.
REQ-030 The state register and next-state logic SHALL remain in lemmings_ctrl.

Verification (FALL_LIMIT=20, CNT_W=5, macro defined)
REQ-031 Reset, then ground=1 and bump_left=1 for one cycle -> walk_left=1 after reset; walk_right=1 one cycle after the bump.
REQ-032 Walking left, drop ground for 20 cycles, then ground=1 -> aaah=1 for 20 cycles with fall_cnt 0..19; next state walk_left=1; fall_cnt=0.
REQ-033 Same with ground dropped for 21 cycles -> splat=1 and stays 1 for 50 further cycles despite random bump, dig and ground; sys_rst=1 -> walk_left=1.
REQ-034 Walking right, dig=1 with bump_right=1 -> digging=1 (dig beats bump); ground=0 -> aaah=1; landing -> walk_right=1.
REQ-035 Walking right, ground=0 with dig=1 and bump_left=1 simultaneously -> aaah=1 (fall has priority); ground held 0 for 40 cycles -> fall_cnt saturates at 31, no wrap; landing -> splat=1.
REQ-036 Macro undefined, 40-cycle fall -> lands to walk_left; fall_cnt=31 at landing, 0 afterwards.

Source files
------------

// File: rtl/lemmings_pkg.sv
// Shared types and default sizing for the lemmings walker controller.
// LEMMINGS_CTRL_SPLAT_EN adds the SPLAT state to the enum.
package lemmings_pkg;

   localparam int LEM_FALL_LIMIT = 20;
   localparam int LEM_CNT_W      = 5;

   typedef enum logic [2:0] {
      WALK_L = 3'd0,
      WALK_R = 3'd1,
      FALL_L = 3'd2,
      FALL_R = 3'd3,
      DIG_L  = 3'd4,
      DIG_R  = 3'd5
`ifdef LEMMINGS_CTRL_SPLAT_EN
      ,
      SPLAT  = 3'd6
`endif
   } lem_state_t;

   function automatic logic is_fall(input lem_state_t s);
      return (s == FALL_L) || (s == FALL_R);
   endfunction

endpackage

// File: rtl/lemmings_fall_cnt.sv
// Saturating fall-cycle counter; holds zero whenever en is low.
module lemmings_fall_cnt #(
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic [CNT_W-1:0] cnt
);

   always_ff @(posedge clk) begin
      if (rst || !en)
         cnt <= '0;
      else if (cnt != {CNT_W{1'b1}})
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/lemmings_ctrl.sv
// Lemmings walker Moore FSM with registered outputs and fall counter.
// Optional LEMMINGS_CTRL_SPLAT_EN enables the SPLAT state and splat port.
//
// state  | meaning
// WALK_L | walking left
// WALK_R | walking right
// FALL_L | falling, resumes walking left on landing
// FALL_R | falling, resumes walking right on landing
// DIG_L  | digging, facing left
// DIG_R  | digging, facing right
// SPLAT  | dead after an over-long fall, held until reset
module lemmings_ctrl
   import lemmings_pkg::*;
#(
   parameter int FALL_LIMIT = LEM_FALL_LIMIT,
   parameter int CNT_W      = LEM_CNT_W
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             bump_left,
   input  logic             bump_right,
   input  logic             ground,
   input  logic             dig,
   output logic             walk_left,
   output logic             walk_right,
   output logic             aaah,
   output logic             digging,
`ifdef LEMMINGS_CTRL_SPLAT_EN
   output logic             splat,
`endif
   output logic [CNT_W-1:0] fall_cnt
);

   if ((2 ** CNT_W) - 1 < FALL_LIMIT) begin : g_bad_cfg
      $error("lemmings_ctrl: CNT_W too narrow to hold FALL_LIMIT");
   end

   lem_state_t state;
   lem_state_t nxt;
   logic       cnt_en;

`ifdef LEMMINGS_CTRL_SPLAT_EN
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(FALL_LIMIT);
`endif

   always_comb begin
      nxt = state;
      case (state)
         WALK_L: begin
            if (!ground)        nxt = FALL_L;
            else if (dig)       nxt = DIG_L;
            else if (bump_left) nxt = WALK_R;
         end
         WALK_R: begin
            if (!ground)         nxt = FALL_R;
            else if (dig)        nxt = DIG_R;
            else if (bump_right) nxt = WALK_L;
         end
         DIG_L:  if (!ground) nxt = FALL_L;
         DIG_R:  if (!ground) nxt = FALL_R;
         FALL_L: begin
            if (ground) begin
               nxt = WALK_L;
`ifdef LEMMINGS_CTRL_SPLAT_EN
               if (fall_cnt >= LIMIT) nxt = SPLAT;
`endif
            end
         end
         FALL_R: begin
            if (ground) begin
               nxt = WALK_R;
`ifdef LEMMINGS_CTRL_SPLAT_EN
               if (fall_cnt >= LIMIT) nxt = SPLAT;
`endif
            end
         end
`ifdef LEMMINGS_CTRL_SPLAT_EN
         SPLAT:  nxt = SPLAT;
`endif
         default: nxt = WALK_L;
      endcase
   end

   // Count only while remaining in a fall, so the first fall cycle reads 0
   // and the landing cycle's successor reads 0 again.
   assign cnt_en = is_fall(state) && is_fall(nxt);

   lemmings_fall_cnt #(.CNT_W(CNT_W)) u_fall_cnt (
      .clk (sys_clk),
      .rst (sys_rst),
      .en  (cnt_en),
      .cnt (fall_cnt)
   );

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state      <= WALK_L;
         walk_left  <= 1'b1;
         walk_right <= 1'b0;
         aaah       <= 1'b0;
         digging    <= 1'b0;
`ifdef LEMMINGS_CTRL_SPLAT_EN
         splat      <= 1'b0;
`endif
      end else begin
         state      <= nxt;
         walk_left  <= (nxt == WALK_L);
         walk_right <= (nxt == WALK_R);
         aaah       <= is_fall(nxt);
         digging    <= (nxt == DIG_L) || (nxt == DIG_R);
`ifdef LEMMINGS_CTRL_SPLAT_EN
         splat      <= (nxt == SPLAT);
`endif
      end
   end

endmodule
